// File: rtl/ex_div_seq_if.sv
// Request/response bundle for the ex_div_seq sequential divider.
interface ex_div_seq_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
);
  logic             iValid;
  logic             oReady;
  logic [1:0]       iOp;
  logic [XLEN-1:0]  iRs1;
  logic [XLEN-1:0]  iRs2;
  logic [TAG_W-1:0] iTag;
  logic             iFlush;
  logic             oValid;
  logic             iReady;
  logic [XLEN-1:0]  oResult;
  logic [TAG_W-1:0] oTag;
  logic             oBusy;

  modport master (
    output iValid, iOp, iRs1, iRs2, iTag, iFlush, iReady,
    input  oReady, oValid, oResult, oTag, oBusy
  );

  modport slave (
    input  iValid, iOp, iRs1, iRs2, iTag, iFlush, iReady,
    output oReady, oValid, oResult, oTag, oBusy
  );
endinterface

// File: rtl/ex_div_seq.sv
// Restoring shift-subtract divider: DIV/DIVU/REM/REMU, XLEN iterations per op.
// Optional EX_DIV_EARLY_OUT_EN finishes |dividend| < |divisor| in one cycle.
module ex_div_seq #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        rst,
  ex_div_seq_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  function automatic logic [XLEN-1:0] neg2c(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  logic [1:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  rem_r;
  logic [XLEN-1:0]  quo_r;
  logic [XLEN-1:0]  dvs_r;
  logic [XLEN-1:0]  result_r;
  logic [TAG_W-1:0] tag_r;
  logic [1:0]       op_r;
  logic             sign1_r;
  logic             sign2_r;

  logic             op_signed_s;
  logic             rs1_neg_s;
  logic             rs2_neg_s;
  logic [XLEN-1:0]  mag1_s;
  logic [XLEN-1:0]  mag2_s;
  logic             div0_s;
  logic             ovf_s;
  logic             early_s;
  logic             fast_s;
  logic [XLEN-1:0]  fast_result_s;

  logic [XLEN:0]    rem_shift_s;
  logic             ge_s;
  logic [XLEN-1:0]  rem_sub_s;
  logic [XLEN-1:0]  rem_next_s;
  logic [XLEN-1:0]  quo_next_s;
  logic [XLEN-1:0]  final_s;

  // Sign bits are only meaningful for DIV/REM; unsigned ops see them as zero.
  assign op_signed_s = ~bus.iOp[0];
  assign rs1_neg_s   = op_signed_s & bus.iRs1[XLEN-1];
  assign rs2_neg_s   = op_signed_s & bus.iRs2[XLEN-1];
  assign mag1_s      = rs1_neg_s ? neg2c(bus.iRs1) : bus.iRs1;
  assign mag2_s      = rs2_neg_s ? neg2c(bus.iRs2) : bus.iRs2;
  assign div0_s      = (bus.iRs2 == {XLEN{1'b0}});
  assign ovf_s       = op_signed_s & (bus.iRs1 == {1'b1, {(XLEN-1){1'b0}}})
                                   & (bus.iRs2 == {XLEN{1'b1}});
`ifdef EX_DIV_EARLY_OUT_EN
  assign early_s     = ~div0_s & (mag1_s < mag2_s);
`else
  assign early_s     = 1'b0;
`endif
  assign fast_s      = div0_s | ovf_s | early_s;

  // One-cycle result for the cases that bypass the iteration.
  always_comb begin
    fast_result_s = {XLEN{1'b0}};
    if (div0_s) begin
      fast_result_s = bus.iOp[1] ? bus.iRs1 : {XLEN{1'b1}};
    end else if (ovf_s) begin
      fast_result_s = bus.iOp[1] ? {XLEN{1'b0}} : bus.iRs1;
    end else begin
      fast_result_s = bus.iOp[1] ? bus.iRs1 : {XLEN{1'b0}};
    end
  end

  // One restoring step; the partial remainder never exceeds the divisor,
  // so the subtraction fits in XLEN bits whenever it is taken.
  assign rem_shift_s = {rem_r, quo_r[XLEN-1]};
  assign ge_s        = (rem_shift_s >= {1'b0, dvs_r});
  assign rem_sub_s   = rem_shift_s[XLEN-1:0] - dvs_r;
  assign rem_next_s  = ge_s ? rem_sub_s : rem_shift_s[XLEN-1:0];
  assign quo_next_s  = {quo_r[XLEN-2:0], ge_s};

  // Sign fix-up applied to the last step's outputs as DONE is entered.
  always_comb begin
    final_s = {XLEN{1'b0}};
    if (op_r[1]) begin
      final_s = sign1_r ? neg2c(rem_next_s) : rem_next_s;
    end else begin
      final_s = (sign1_r ^ sign2_r) ? neg2c(quo_next_s) : quo_next_s;
    end
  end

  // Control FSM and datapath registers: rst, then flush, then normal flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      dvs_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      tag_r    <= {TAG_W{1'b0}};
      op_r     <= 2'b00;
      sign1_r  <= 1'b0;
      sign2_r  <= 1'b0;
    end else if (bus.iFlush) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.iValid) begin
            op_r    <= bus.iOp;
            tag_r   <= bus.iTag;
            sign1_r <= rs1_neg_s;
            sign2_r <= rs2_neg_s;
            dvs_r   <= mag2_s;
            quo_r   <= mag1_s;
            rem_r   <= {XLEN{1'b0}};
            if (fast_s) begin
              result_r <= fast_result_s;
              state_r  <= ST_DONE;
            end else begin
              cnt_r   <= CNT_W'(XLEN - 1);
              state_r <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CALC: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          if (cnt_r == {CNT_W{1'b0}}) begin
            result_r <= final_s;
            state_r  <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.iReady) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.oReady  = (state_r == ST_IDLE) & ~bus.iFlush;
  assign bus.oValid  = (state_r == ST_DONE);
  assign bus.oBusy   = (state_r != ST_IDLE);
  assign bus.oResult = result_r;
  assign bus.oTag    = tag_r;
endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq (XLEN=32): directed latency/value cases
// plus randomized traffic checked every cycle against an arithmetic model.
module tb_ex_div_seq;
  localparam int XLEN     = 32;
  localparam int TAG_W    = 5;
  localparam int FULL_LAT = XLEN + 1;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_div_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();
  ex_div_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural result: plain SV arithmetic, truncating signed division.
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op, input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [XLEN-1:0] q, r;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1; r = a;
    end else if (!op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
      q = a; r = '0;
    end else if (!op[0]) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] ma, mb;
    ma = (!op[0] && a[XLEN-1]) ? -a : a;
    mb = (!op[0] && b[XLEN-1]) ? -b : b;
    if (b == '0) return 1;
    if (!op[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) return 1;
`ifdef EX_DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return FULL_LAT;
`endif
    return FULL_LAT;
  endfunction

  // Model: one op in flight, a countdown until the result shows, then handoff.
  bit               m_busy = 1'b0;
  int               m_wait = 0;
  logic [XLEN-1:0]  m_res  = '0;
  logic [TAG_W-1:0] m_tag  = '0;

  always @(posedge clk) begin
    if (rst || bus.iFlush) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (bus.iValid) begin
        m_busy <= 1'b1;
        m_wait <= ref_lat(bus.iOp, bus.iRs1, bus.iRs2) - 1;
        m_res  <= ref_result(bus.iOp, bus.iRs1, bus.iRs2);
        m_tag  <= bus.iTag;
      end
    end else if (m_wait != 0) begin
      m_wait <= m_wait - 1;
    end else if (bus.iReady) begin
      m_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {63'd0, bus.oValid}, {63'd0, (m_busy && m_wait == 0)});
      check("busy", {63'd0, bus.oBusy}, {63'd0, m_busy});
      check("ready", {63'd0, bus.oReady}, {63'd0, (!m_busy && !bus.iFlush)});
      if (m_busy && m_wait == 0) begin
        check("result", 64'(bus.oResult), 64'(m_res));
        check("tag", 64'(bus.oTag), 64'(m_tag));
      end
    end
  end

  function automatic logic [XLEN-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return {1'b1, {(XLEN-1){1'b0}}};
      2: return '1;
      3: return XLEN'($urandom_range(0, 15));
      4: return -XLEN'($urandom_range(1, 15));
      default: return XLEN'($urandom);
    endcase
  endfunction

  task automatic idle_inputs();
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;
    bus.iOp    = 2'($urandom);
    bus.iRs1   = XLEN'($urandom);
    bus.iRs2   = XLEN'($urandom);
    bus.iTag   = TAG_W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted; returns the accept cycle T.
  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] tag, output int t_acc);
    bus.iValid = 1'b1; bus.iOp = op; bus.iRs1 = a; bus.iRs2 = b; bus.iTag = tag;
    t_acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.oReady) begin
        t_acc = cyc;
        break;
      end
      tick();
    end
    if (t_acc < 0) check("accept_timeout", 64'd0, 64'd1);
    tick();
    idle_inputs();
  endtask

  // Returns at the negedge where oValid is first seen.
  task automatic wait_valid(input int t_acc, input int exp_lat, input logic [XLEN-1:0] exp_res,
                            input string name);
    int t_v;
    t_v = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.oValid) begin
        t_v = cyc;
        break;
      end
    end
    check({name, "_lat"}, 64'(t_v - t_acc), 64'(exp_lat));
    check({name, "_res"}, 64'(bus.oResult), 64'(exp_res));
  endtask

  initial begin
    int  t;
    bit  seen;
    bus.iReady = 1'b1;
    idle_inputs();
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {63'd0, bus.oReady}, 64'd1);
    check("rst_valid", {63'd0, bus.oValid}, 64'd0);
    check("rst_busy", {63'd0, bus.oBusy}, 64'd0);
    check("rst_result", 64'(bus.oResult), 64'd0);
    check("rst_tag", 64'(bus.oTag), 64'd0);
    chk_en = 1'b1;
    tick();

    check("model_divu", 64'(ref_result(OP_DIVU, 32'd100, 32'd7)), 64'd14);
    check("model_rem", 64'(ref_result(OP_REM, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFF);
    check("model_div", 64'(ref_result(OP_DIV, 32'hFFFF_FFF9, 32'd2)), 64'hFFFF_FFFD);

    issue(OP_DIVU, 32'd100, 32'd7, 5'd1, t);          wait_valid(t, 33, 32'd14, "divu"); tick();
    issue(OP_REMU, 32'd100, 32'd7, 5'd2, t);          wait_valid(t, 33, 32'd2, "remu"); tick();
    issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd3, t);     wait_valid(t, 33, 32'hFFFF_FFFF, "rem_neg"); tick();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, t);     wait_valid(t, 33, 32'hFFFF_FFFD, "div_neg"); tick();
    issue(OP_DIV, 32'd5, 32'd0, 5'd5, t);             wait_valid(t, 1, 32'hFFFF_FFFF, "div0"); tick();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, t); wait_valid(t, 1, 32'h8000_0000, "ovf_div"); tick();
    issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, t); wait_valid(t, 1, 32'd0, "ovf_rem"); tick();
`ifdef EX_DIV_EARLY_OUT_EN
    issue(OP_DIVU, 32'd3, 32'd10, 5'd8, t);           wait_valid(t, 1, 32'd0, "small"); tick();
`else
    issue(OP_DIVU, 32'd3, 32'd10, 5'd8, t);           wait_valid(t, 33, 32'd0, "small"); tick();
`endif

    // Flush mid-CALC: no result, ready again the next cycle.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd9, t);
    while (cyc < t + 10) tick();
    bus.iFlush = 1'b1;
    tick();
    bus.iFlush = 1'b0;
    @(negedge clk);
    check("flush_ready", {63'd0, bus.oReady}, 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.oValid) seen = 1'b1;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);
    tick();
    issue(OP_DIVU, 32'd100, 32'd7, 5'd10, t);         wait_valid(t, 33, 32'd14, "after_flush"); tick();

    // Backpressure: result and tag held while iReady is low.
    bus.iReady = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 5'd9, t);
    wait_valid(t, 33, 32'd14, "bp");
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {63'd0, bus.oValid}, 64'd1);
      check("bp_result", 64'(bus.oResult), 64'd14);
      check("bp_tag", 64'(bus.oTag), 64'd9);
      check("bp_ready", {63'd0, bus.oReady}, 64'd0);
      tick();
      if (k == 4) bus.iReady = 1'b1;
      @(negedge clk);
    end
    check("bp_last_valid", {63'd0, bus.oValid}, 64'd1);
    tick();
    @(negedge clk);
    check("bp_handoff_valid", {63'd0, bus.oValid}, 64'd0);
    check("bp_handoff_ready", {63'd0, bus.oReady}, 64'd1);
    tick();

    // Reset in the middle of CALC.
    issue(OP_DIVU, 32'h0000_FFFF, 32'd3, 5'd17, t);
    while (cyc < t + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {63'd0, bus.oValid}, 64'd0);
    check("mid_rst_busy", {63'd0, bus.oBusy}, 64'd0);
    check("mid_rst_result", 64'(bus.oResult), 64'd0);
    check("mid_rst_tag", 64'(bus.oTag), 64'd0);
    check("mid_rst_ready", {63'd0, bus.oReady}, 64'd1);
    tick();

    // Random traffic: every input random every cycle, checked by the model.
    for (int c = 0; c < 4000; c++) begin
      bus.iValid = 1'($urandom_range(0, 1));
      bus.iOp    = 2'($urandom);
      bus.iRs1   = pick();
      bus.iRs2   = pick();
      bus.iTag   = TAG_W'($urandom);
      bus.iReady = ($urandom_range(0, 3) != 0);
      bus.iFlush = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    bus.iReady = 1'b1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ex_div_seq.md
EX_DIV_SEQ -- requirements
Module: ex_div_seq

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand/result width (any even value 8..64).
REQ-002 SHALL have parameter TAG_W, default 5: width of the destination tag carried alongside the operation.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port iValid, input, 1: request present.
REQ-006 SHALL have port oReady, output, 1: unit can accept a request this cycle.
REQ-007 SHALL have port iOp, input, 2: operation select, 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 SHALL have port iRs1, input, XLEN: dividend.
REQ-009 SHALL have port iRs2, input, XLEN: divisor.
REQ-010 SHALL have port iTag, input, TAG_W: destination tag.
REQ-011 SHALL have port iFlush, input, 1: kill any in-flight or pending operation.
REQ-012 SHALL have port oValid, output, 1: result present.
REQ-013 SHALL have port iReady, input, 1: consumer accepts the result.
REQ-014 SHALL have port oResult, output, XLEN: quotient or remainder per iOp.
REQ-015 SHALL have port oTag, output, TAG_W: tag of the result.
REQ-016 SHALL have port oBusy, output, 1: high whenever state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, CALC, DONE; oReady = (state==IDLE) and not iFlush.
REQ-018 Accept: iValid&&oReady at cycle T; SHALL latch iOp, iTag, operand magnitudes and both operand signs.
REQ-019 Signed ops (DIV, REM) SHALL use two's-complement magnitudes; unsigned ops SHALL use operands as given.
REQ-020 Normal path: IDLE->CALC at T+1; CALC SHALL run exactly XLEN restoring shift-subtract iterations driven by a down-counter; DONE entered, oValid high, from T+XLEN+1.
REQ-021 Sign fix-up SHALL be applied on CALC->DONE: quotient negated iff operand signs differ; remainder takes the dividend's sign.
REQ-022 Divide by zero SHALL go IDLE->DONE at T+1: quotient all ones, remainder = iRs1.
REQ-023 Signed overflow (iRs1 = most-negative, iRs2 = -1, DIV/REM) SHALL go IDLE->DONE at T+1: quotient = iRs1, remainder 0.
REQ-024 DONE SHALL hold oResult and oTag stable while iReady is low; DONE&&iReady SHALL transition to IDLE next cycle.
REQ-025 No accept in the cycle DONE completes (oReady low in DONE); minimum issue spacing therefore excludes back-to-back overlap.
REQ-026 iFlush SHALL force state to IDLE next cycle from any state; oValid low from that cycle; iFlush has priority over accept and over DONE handoff.
REQ-027 oValid SHALL be high only in DONE; oResult and oTag SHALL be don't-care when oValid is low.
REQ-028 Inputs other than iValid/iFlush SHALL be ignored outside the accept cycle.

Reset
REQ-029 rst high SHALL force state IDLE, counter 0, oValid 0, oBusy 0, oResult 0, oTag 0 on the next edge, including mid-CALC; rst has priority over iFlush and accept.
REQ-030 oReady SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-031 Macro EX_DIV_EARLY_OUT_EN defined: if |dividend| < |divisor| (nonzero divisor) the unit SHALL go IDLE->DONE at T+1 with quotient 0, remainder = iRs1.
REQ-032 Macro undefined: that case SHALL take the normal XLEN-iteration path with identical results; only latency differs.

Verification (XLEN=32)
REQ-033 DIVU 100/7 accepted at T, iReady high -> oValid at T+33, oResult 14; REMU same operands -> 2.
REQ-034 REM 0xFFFFFFF9 (-7) / 2 -> oResult 0xFFFFFFFF; DIV same -> 0xFFFFFFFD (-3), full latency.
REQ-035 DIV 5/0 -> oValid at T+1, 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at T+1, REM -> 0.
REQ-036 iFlush at T+10 during CALC -> oValid never asserts, oReady high at T+11, new request then completes normally.
REQ-037 iReady low for 5 cycles in DONE -> oValid, oResult, oTag stable throughout; oReady low until cycle after handoff.
REQ-038 DIVU 3/10 -> oResult 0 at T+1 with EX_DIV_EARLY_OUT_EN, at T+33 without; rst at T+5 -> all outputs 0 next cycle.
